fbpgen: RTL and testbench

//  Feedback-pulse generator: emits rising edges on fbp_out at a commanded rate of N edges per

---
 rtl/fbp_pkg.sv | 21 ++
 rtl/fbpgen_shaper.sv | 75 +++++++
 rtl/fbpgen.sv | 131 +++++++++++++
 tb/tb_fbpgen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fbp_pkg.sv
// Definitions shared by both ends of the feedback-pulse interface:
// the default window length, the rate width and the pulse FSM state encoding.
package fbp_pkg;

  localparam int unsigned FBP_WINDOW_CYCLES_DEF = 125000000;
  localparam int unsigned FBP_RATE_W            = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } fbp_state_e;

  // Highest rate whose evenly spaced events still leave room for a full high and low phase.
  function automatic int unsigned fbp_rate_max(input int unsigned window,
                                                input int unsigned hi,
                                                input int unsigned lo);
    return window / (hi + lo);
  endfunction

endpackage

// File: rtl/fbpgen_shaper.sv
// Pulse shaper for fbpgen: turns single-cycle spacing events into fixed-width
// high pulses on a registered output.
module fbpgen_shaper
  import fbp_pkg::*;
#(
  parameter int unsigned PULSE_HI = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic event_i,
  input  logic rate_nz_i,
  output logic fbp_o
);

  localparam int unsigned HI_W = (PULSE_HI > 1) ? $clog2(PULSE_HI) : 1;

  fbp_state_e      state_q, state_d;
  logic [HI_W-1:0] hi_cnt_q, hi_cnt_d;
  logic            fbp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hi_cnt_q <= '0;
      fbp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_cnt_q <= hi_cnt_d;
      fbp_q    <= (state_d == S_HIGH);
    end
  end

  // Events arriving while high are dropped; a pulse always runs its full width.
  always_comb begin
    state_d  = state_q;
    hi_cnt_d = hi_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (rate_nz_i) begin
          if (event_i) begin
            state_d  = S_HIGH;
            hi_cnt_d = '0;
          end else begin
            state_d = S_LOW;
          end
        end
      end
      S_LOW: begin
        if (event_i) begin
          state_d  = S_HIGH;
          hi_cnt_d = '0;
        end else if (!rate_nz_i) begin
          state_d = S_IDLE;
        end
      end
      S_HIGH: begin
        if (hi_cnt_q == HI_W'(PULSE_HI - 1)) begin
          state_d = rate_nz_i ? S_LOW : S_IDLE;
        end else begin
          hi_cnt_d = hi_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(state_q == S_HIGH && event_i));
    end
  end

  assign fbp_o = fbp_q;

endmodule

// File: rtl/fbpgen.sv
// Feedback-pulse generator: N evenly spaced rising edges per counting window.
// Define FBPGEN_STAT_EN to add the per-window edge counter and its edge_cnt_out port.
module fbpgen
  import fbp_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = FBP_WINDOW_CYCLES_DEF,
  parameter int unsigned PULSE_HI      = 16,
  parameter int unsigned PULSE_LO      = 16,
  parameter int unsigned RATE_W        = FBP_RATE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [RATE_W-1:0] rate_in,
  input  logic              rate_we,
  output logic              fbp_out,
  output logic              win_tick,
  output logic [RATE_W-1:0] rate_act,
  output logic              rate_sat
`ifdef FBPGEN_STAT_EN
  ,
  output logic [RATE_W-1:0] edge_cnt_out
`endif
);

  localparam int unsigned RATE_MAX = fbp_rate_max(WINDOW_CYCLES, PULSE_HI, PULSE_LO);
  localparam int unsigned WIN_W    = $clog2(WINDOW_CYCLES);
  localparam int unsigned ACC_W    = $clog2(2 * WINDOW_CYCLES);

  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [RATE_W-1:0] shadow_q, shadow_d;
  logic [RATE_W-1:0] rate_act_q, rate_act_d;
  logic              rate_sat_q, rate_sat_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic              tick, dda_event;

  assign tick = (win_cnt_q == WIN_W'(WINDOW_CYCLES - 1));

  // A write on the boundary cycle goes through shadow_d, so it lands in the very next window.
  always_comb begin
    win_cnt_d  = tick ? '0 : win_cnt_q + 1'b1;
    shadow_d   = rate_we ? rate_in : shadow_q;
    rate_act_d = rate_act_q;
    rate_sat_d = rate_sat_q;
    if (tick) begin
      if (en) begin
        rate_sat_d = (32'(shadow_d) > RATE_MAX);
        rate_act_d = rate_sat_d ? RATE_W'(RATE_MAX) : shadow_d;
      end else begin
        rate_sat_d = 1'b0;
        rate_act_d = '0;
      end
    end
    acc_sum   = acc_q + ACC_W'(rate_act_q);
    dda_event = (acc_sum >= ACC_W'(WINDOW_CYCLES));
    acc_d     = dda_event ? acc_sum - ACC_W'(WINDOW_CYCLES) : acc_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_q  <= '0;
      shadow_q   <= '0;
      rate_act_q <= '0;
      rate_sat_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      shadow_q   <= shadow_d;
      rate_act_q <= rate_act_d;
      rate_sat_q <= rate_sat_d;
      acc_q      <= acc_d;
    end
  end

  // The accumulator sums rate*WINDOW over a window, so it must be empty at every boundary.
  always_ff @(posedge clk) begin
    if (!rst && tick) begin
      assert (acc_d == '0);
    end
  end

  fbpgen_shaper #(
    .PULSE_HI (PULSE_HI)
  ) u_shaper (
    .clk       (clk),
    .rst       (rst),
    .event_i   (dda_event),
    .rate_nz_i (|rate_act_q),
    .fbp_o     (fbp_out)
  );

  assign win_tick = tick;
  assign rate_act = rate_act_q;
  assign rate_sat = rate_sat_q;

`ifdef FBPGEN_STAT_EN
  logic              fbp_prev_q;
  logic              rise;
  logic [RATE_W-1:0] edge_acc_q, edge_acc_d;
  logic [RATE_W-1:0] edge_cnt_q, edge_cnt_d;

  // An edge on the boundary cycle is folded in before the latch, so it counts in the closing window.
  always_comb begin
    rise       = fbp_out & ~fbp_prev_q;
    edge_acc_d = edge_acc_q;
    edge_cnt_d = edge_cnt_q;
    if (rise && (edge_acc_q != '1)) begin
      edge_acc_d = edge_acc_q + 1'b1;
    end
    if (tick) begin
      edge_cnt_d = edge_acc_d;
      edge_acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fbp_prev_q <= 1'b0;
      edge_acc_q <= '0;
      edge_cnt_q <= '0;
    end else begin
      fbp_prev_q <= fbp_out;
      edge_acc_q <= edge_acc_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign edge_cnt_out = edge_cnt_q;
`endif

endmodule

// File: tb/tb_fbpgen.sv
// Directed self-checking bench for fbpgen with a 1000-cycle window and 4/4 pulse timing.
// Edge counts, spacings and pulse widths are measured per window and compared to hand-computed values.
module tb_fbpgen;

  localparam int unsigned WC = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        rate_we = 1'b0;
  logic [15:0] rate_in = 16'd0;
  logic        fbp_out;
  logic        win_tick;
  logic [15:0] rate_act;
  logic        rate_sat;
`ifdef FBPGEN_STAT_EN
  logic [15:0] edge_cnt_out;
`endif

  int compared = 0;
  int mismatched = 0;

  int tbCnt = 0;
  int winSeq = 0;
  int gcyc = 0;
  int lastRise = -1;
  int winRises = 0;
  int minSp = 1 << 30;
  int maxSp = 0;
  int highLen = 0;
  int badHigh = 0;
  int sp;
  int lastRises = 0;
  int lastMin = 0;
  int lastMax = 0;
  int lastBad = 0;
  logic prevFbp = 1'b0;

  always #5 clk = ~clk;

  fbpgen #(
    .WINDOW_CYCLES (WC),
    .PULSE_HI      (4),
    .PULSE_LO      (4),
    .RATE_W        (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .rate_in  (rate_in),
    .rate_we  (rate_we),
    .fbp_out  (fbp_out),
    .win_tick (win_tick),
    .rate_act (rate_act),
    .rate_sat (rate_sat)
`ifdef FBPGEN_STAT_EN
    ,
    .edge_cnt_out (edge_cnt_out)
`endif
  );

  // Reference window position: cycle 0 is the first cycle after reset is released.
  always @(posedge clk) begin
    if (rst) tbCnt <= 0;
    else     tbCnt <= (tbCnt == WC - 1) ? 0 : tbCnt + 1;
  end

  // Per-window measurement of rising edges, edge spacing and high-pulse width, latched on the last cycle.
  always @(negedge clk) begin
    if (rst) begin
      winRises = 0;
      minSp    = 1 << 30;
      maxSp    = 0;
      highLen  = 0;
      badHigh  = 0;
      prevFbp  = 1'b0;
      lastRise = -1;
    end else begin
      gcyc++;
      if (fbp_out && !prevFbp) begin
        winRises++;
        if (lastRise >= 0) begin
          sp = gcyc - lastRise;
          if (sp < minSp) minSp = sp;
          if (sp > maxSp) maxSp = sp;
        end
        lastRise = gcyc;
      end
      if (fbp_out) begin
        highLen++;
      end else if (prevFbp) begin
        if (highLen != 4) badHigh++;
        highLen = 0;
      end
      prevFbp = fbp_out;
      if (tbCnt == WC - 1) begin
        lastRises = winRises;
        lastMin   = minSp;
        lastMax   = maxSp;
        lastBad   = badHigh;
        winRises  = 0;
        minSp     = 1 << 30;
        maxSp     = 0;
        badHigh   = 0;
        winSeq++;
      end
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Writes a rate and enable value, holding the write strobe for exactly one clock.
  task automatic applyStimulus(input logic [15:0] rate, input logic enVal);
    en      = enVal;
    rate_in = rate;
    rate_we = 1'b1;
    @(posedge clk);
    #2;
    rate_we = 1'b0;
  endtask

  task automatic waitWindow();
    int start;
    int n;
    start = winSeq;
    n = 0;
    while (winSeq == start && n < 1200) begin
      @(negedge clk);
      n++;
    end
    if (winSeq == start) checkOutput("windowTimeout", 0, 1);
  endtask

  // Leaves the caller 2 time units after the edge that starts window cycle 'target'.
  task automatic waitCount(input int target);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (tbCnt != target && n < 1200);
    if (tbCnt != target) checkOutput("countTimeout", tbCnt, target);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstFbp", int'(fbp_out), 0);
    checkOutput("rstTick", int'(win_tick), 0);
    checkOutput("rstRateAct", int'(rate_act), 0);
    checkOutput("rstSat", int'(rate_sat), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(16'd10, 1'b1);

    waitWindow();
    checkOutput("w0Rises", lastRises, 0);
    checkOutput("w1RateAct", int'(rate_act), 10);
    waitWindow();
    checkOutput("w1Rises", lastRises, 9);
    waitWindow();
    checkOutput("w2Rises", lastRises, 10);
    checkOutput("w2MinSp", lastMin, 100);
    checkOutput("w2MaxSp", lastMax, 100);
    checkOutput("w2BadHigh", lastBad, 0);
    checkOutput("w3Sat", int'(rate_sat), 0);
`ifdef FBPGEN_STAT_EN
    checkOutput("w2EdgeCnt", int'(edge_cnt_out), 10);
`endif

    waitCount(500);
    applyStimulus(16'd50, 1'b1);
    waitWindow();
    checkOutput("w3Rises", lastRises, 10);
    checkOutput("w4RateAct", int'(rate_act), 50);

    waitCount(999);
    checkOutput("w4Tick", int'(win_tick), 1);
    applyStimulus(16'd200, 1'b1);
    @(negedge clk);
    checkOutput("w4Rises", lastRises, 50);
    checkOutput("w4MinSp", lastMin, 20);
    checkOutput("w4MaxSp", lastMax, 100);
    checkOutput("w5RateAct", int'(rate_act), 125);
    checkOutput("w5Sat", int'(rate_sat), 1);
    checkOutput("w5TickLow", int'(win_tick), 0);

    waitWindow();
    checkOutput("w5Rises", lastRises, 125);
    checkOutput("w5MinSp", lastMin, 8);
    checkOutput("w5MaxSp", lastMax, 20);
    en = 1'b0;
    waitWindow();
    checkOutput("w6Rises", lastRises, 125);
    checkOutput("w6MinSp", lastMin, 8);
    checkOutput("w6MaxSp", lastMax, 8);
    checkOutput("w6BadHigh", lastBad, 0);
`ifdef FBPGEN_STAT_EN
    checkOutput("w6EdgeCnt", int'(edge_cnt_out), 125);
`endif
    checkOutput("w7RateAct", int'(rate_act), 0);
    checkOutput("w7Sat", int'(rate_sat), 0);

    waitWindow();
    checkOutput("w7Rises", lastRises, 1);
    checkOutput("w7BadHigh", lastBad, 0);
    applyStimulus(16'd0, 1'b1);
    waitWindow();
    checkOutput("w8Rises", lastRises, 0);
    checkOutput("w9RateAct", int'(rate_act), 0);
    applyStimulus(16'd10, 1'b1);
    waitWindow();
    checkOutput("w9Rises", lastRises, 0);

    waitCount(101);
    @(negedge clk);
    checkOutput("preRstHigh", int'(fbp_out), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("midRstFbp", int'(fbp_out), 0);
    checkOutput("midRstRateAct", int'(rate_act), 0);
    checkOutput("midRstTick", int'(win_tick), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(16'd10, 1'b1);
    waitWindow();
    checkOutput("n0Rises", lastRises, 0);
    waitWindow();
    checkOutput("n1Rises", lastRises, 9);
    waitWindow();
    checkOutput("n2Rises", lastRises, 10);
    checkOutput("n2MinSp", lastMin, 100);
    checkOutput("n2BadHigh", lastBad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
